// File: rtl/frame_mem_arb_pkg.sv
// Shared definitions for the frame RAM arbiter: arbiter state encoding,
// client indices and the round-robin successor helper.
package frame_mem_arb_pkg;

  localparam int unsigned NUM_CLI = 3;

  localparam logic [1:0] CLI_CAM  = 2'd0;
  localparam logic [1:0] CLI_GS   = 2'd1;
  localparam logic [1:0] CLI_FILT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Successor client in round-robin order (2 wraps to 0; 3 is treated as 2).
  function automatic logic [1:0] next_cli(input logic [1:0] c);
    return (c >= CLI_FILT) ? CLI_CAM : c + 2'd1;
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   req_i    [2:0]  per-client request
//   rr_ptr_i [1:0]  highest-priority client this round (3 treated as 0)
//   any_o           at least one client requesting
//   idx_o    [1:0]  first requesting client scanning rr_ptr, +1, +2 (mod 3)
module rr_picker
  import frame_mem_arb_pkg::*;
(
  input  logic [NUM_CLI-1:0] req_i,
  input  logic [1:0]         rr_ptr_i,
  output logic               any_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand0, cand1, cand2;

  always_comb begin
    cand0 = (rr_ptr_i > CLI_FILT) ? CLI_CAM : rr_ptr_i;
    cand1 = next_cli(cand0);
    cand2 = next_cli(cand1);
    any_o = 1'b1;
    idx_o = cand0;
    if (req_i[cand0]) begin
      idx_o = cand0;
    end else if (req_i[cand1]) begin
      idx_o = cand1;
    end else if (req_i[cand2]) begin
      idx_o = cand2;
    end else begin
      any_o = 1'b0;
      idx_o = CLI_CAM;
    end
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: round-robin burst arbiter sharing one single-port frame
// RAM among camera writer (0), grayscaler (1) and filter (2).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req/we/last [2:0]     per-client beat request, write flag, final beat
//   addr  [3*AW-1:0]      per-client address, client i at [i*AW +: AW]
//   wdata [3*DW-1:0]      per-client write data, client i at [i*DW +: DW]
//   gnt   [2:0]           one-hot burst owner (registered state decode)
//   ack   [2:0]           beat accepted this cycle (gnt & req)
//   rvalid[2:0], rdata    read return, one cycle after a read beat
//   mem_en/we/addr/wdata  RAM command, driven only on a beat
//   mem_rdata             RAM read data, valid one cycle after access
module frame_mem_arbiter
  import frame_mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 17,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CLI-1:0]    req,
  input  logic [NUM_CLI-1:0]    we,
  input  logic [NUM_CLI*AW-1:0] addr,
  input  logic [NUM_CLI*DW-1:0] wdata,
  input  logic [NUM_CLI-1:0]    last,
  output logic [NUM_CLI-1:0]    gnt,
  output logic [NUM_CLI-1:0]    ack,
  output logic [NUM_CLI-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  // beat_cnt + 1 == MAX_BURST, compared on the current count
  localparam logic [CW-1:0] CNT_FINAL = CW'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_CLI-1:0] rvalid_q, rvalid_d;

  logic               pick_any;
  logic [1:0]         pick_idx;

  logic               own_req, own_we, own_last;
  logic [AW-1:0]      own_addr;
  logic [DW-1:0]      own_wdata;

  rr_picker u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .any_o    (pick_any),
    .idx_o    (pick_idx)
  );

  // Owner's request slice; an illegal owner selects nothing.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_last  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned i = 0; i < NUM_CLI; i++) begin
      if (owner_q == 2'(i)) begin
        own_req   = req[i];
        own_we    = we[i];
        own_last  = last[i];
        own_addr  = addr[i*AW +: AW];
        own_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rvalid_d   = '0;
    gnt        = '0;
    ack        = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (owner_q > CLI_FILT) begin
          state_d = IDLE;
        end else begin
          gnt = 3'b001 << owner_q;
          if (own_req) begin
            ack        = 3'b001 << owner_q;
            mem_en     = 1'b1;
            mem_we     = own_we;
            mem_addr   = own_addr;
            mem_wdata  = own_wdata;
            beat_cnt_d = beat_cnt_q + CW'(1);
            rvalid_d   = own_we ? 3'b000 : (3'b001 << owner_q);
          end
          // With own_req high the beat is implied, so last / cap need no
          // separate beat qualifier; a dropped request releases at once.
          if (!own_req || own_last || (beat_cnt_q == CNT_FINAL)) begin
            state_d  = GAP;
            rr_ptr_d = next_cli(owner_q);
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= CLI_CAM;
      rr_ptr_q   <= CLI_CAM;
      beat_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
module tb_frame_mem_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MB = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req, we, last, gnt, ack, rvalid;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  frame_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .last(last), .gnt(gnt), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // RAM model: unwritten locations read back as addr+5.
  bit            ram_wr [0:(1<<AW)-1];
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : DW'(mem_addr + 5);
      end
    end
  end

  // Client stimulus: each client works through a queue of burst jobs.
  typedef struct { int delay; int beats; bit we; int addr; bit use_last; } job_t;
  job_t          jq [3][$];
  bit            c_act [3];
  int            c_left[3];
  bit            c_we  [3];
  bit            c_ul  [3];
  logic [AW-1:0] c_addr[3];
  logic [DW-1:0] c_wd  [3];
  bit            acked [3];

  task automatic push_job(input int c, input int dly, input int beats, input bit w,
                          input int a, input bit ul);
    job_t j;
    j.delay = dly; j.beats = beats; j.we = w; j.addr = a; j.use_last = ul;
    jq[c].push_back(j);
  endtask

  initial begin : driver
    job_t j;
    for (int c = 0; c < 3; c++) begin
      c_act[c] = 0; c_left[c] = 0; c_addr[c] = '0; c_wd[c] = '0; c_we[c] = 0; c_ul[c] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
        if (!rst_n) begin
          c_act[c] = 0;
        end else begin
          if (acked[c]) begin
            c_left[c]--;
            c_addr[c]++;
            c_wd[c] = DW'($urandom);
            if (c_left[c] == 0) c_act[c] = 0;
          end
          if (!c_act[c] && jq[c].size() > 0) begin
            if (jq[c][0].delay > 0) begin
              j = jq[c][0]; j.delay--; jq[c][0] = j;
            end else begin
              j = jq[c].pop_front();
              c_act[c] = 1; c_left[c] = j.beats; c_we[c] = j.we;
              c_addr[c] = AW'(j.addr); c_ul[c] = j.use_last; c_wd[c] = DW'($urandom);
            end
          end
        end
        req[c]  = c_act[c];
        we[c]   = c_act[c] && c_we[c];
        last[c] = c_act[c] && c_ul[c] && (c_left[c] == 1);
        addr[c*AW +: AW]  = c_addr[c];
        wdata[c*DW +: DW] = c_wd[c];
      end
    end
  end

  // Reference model: owner (-1 = none), beats in the current burst, the
  // priority pointer and a pending turnaround cycle.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  bit m_gap   = 0;

  typedef struct { logic [DW-1:0] d; int stamp; } rd_t;
  rd_t           rq [3][$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic int pick(input bit [2:0] r, input int ptr);
    for (int k = 0; k < 3; k++) if (r[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  initial begin : model
    logic [2:0]       exp_gnt, exp_ack;
    logic [AW+DW+1:0] exp_mem;
    bit               beat;
    int               o;
    rd_t              r;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = DW'(i + 5);
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) acked[c] = 0;
      if (!rst_n) begin
        m_owner = -1; m_beats = 0; m_ptr = 0; m_gap = 0;
      end else begin
        o       = m_owner;
        exp_gnt = (o >= 0) ? 3'(1 << o) : 3'b000;
        beat    = (o >= 0) && c_act[o];
        exp_ack = beat ? exp_gnt : 3'b000;
        exp_mem = '0;
        if (beat) exp_mem = {1'b1, c_we[o], c_addr[o], c_wd[o]};
        chk("gnt", gnt, exp_gnt);
        chk("ack", ack, exp_ack);
        chk("mem_bus", {mem_en, mem_we, mem_addr, mem_wdata}, exp_mem);
        if (beat) begin
          acked[o] = 1;
          m_beats++;
          if (c_we[o]) ref_mem[c_addr[o]] = c_wd[o];
          else begin
            r.d = ref_mem[c_addr[o]]; r.stamp = cyc;
            rq[o].push_back(r);
          end
        end
        if (o >= 0) begin
          if (!c_act[o] || (beat && c_ul[o] && c_left[o] == 1) || m_beats == MB) begin
            m_ptr = (o + 1) % 3; m_owner = -1; m_gap = 1;
          end
        end else if (m_gap) begin
          m_gap = 0;
        end else if (c_act[0] || c_act[1] || c_act[2]) begin
          m_owner = pick({c_act[2], c_act[1], c_act[0]}, m_ptr);
          m_beats = 0;
        end
      end
    end
  end

  // Read-return monitor.
  initial begin : monitor
    rd_t r;
    bit  exp_rv;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (!rst_n) begin
          rq[c].delete();
          chk("rvalid_in_reset", rvalid[c], 1'b0);
        end else begin
          exp_rv = (rq[c].size() > 0) && (rq[c][0].stamp < cyc);
          chk($sformatf("rvalid%0d", c), rvalid[c], exp_rv);
          if (exp_rv) begin
            r = rq[c].pop_front();
            if (rvalid[c]) chk($sformatf("rdata%0d", c), rdata, r.d);
          end
        end
      end
    end
  end

  function automatic bit all_idle();
    for (int c = 0; c < 3; c++) if (c_act[c] || jq[c].size() > 0) return 0;
    return (m_owner < 0) && !m_gap;
  endfunction

  task automatic wait_idle(input int max);
    int n = 0;
    while (n < max && !all_idle()) begin @(negedge clk); n++; end
    if (n >= max) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: waited %0d cycles, required idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sig(input string name, input int c, input bit use_ack, input int max);
    int n = 0;
    while (n < max && !(use_ack ? ack[c] : gnt[c])) begin @(negedge clk); n++; end
    if (n >= max) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: client %0d not seen within %0d cycles", name, c, max);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) jq[c].delete();
    #1;
    chk("reset_outputs", {gnt, ack, rvalid, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b1; req = '0; we = '0; last = '0; addr = '0; wdata = '0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {gnt, ack, rvalid, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Client 0 writes 4 beats at 0..3 with last.
    push_job(0, 0, 4, 1, 0, 1);
    wait_idle(100);

    // Fresh priority: all clients request 2-beat bursts, client 0 twice.
    do_reset();
    push_job(0, 0, 2, 1, 20, 1);
    push_job(0, 0, 2, 0, 22, 1);
    push_job(1, 0, 2, 0, 24, 1);
    push_job(2, 0, 2, 1, 26, 1);
    wait_idle(200);

    // Client 2 reads 10..12, expecting 15,16,17.
    push_job(2, 0, 3, 0, 10, 1);
    wait_idle(100);

    // Client 1 streams without last; client 0 waits behind it.
    push_job(1, 0, 70, 1, 100, 0);
    wait_sig("gnt", 1, 0, 50);
    push_job(0, 0, 2, 0, 100, 1);
    wait_idle(400);

    // Client 0 drops req after 3 beats; client 2 waits, client 0 re-requests.
    push_job(0, 0, 3, 1, 200, 0);
    wait_sig("gnt", 0, 0, 50);
    push_job(2, 0, 2, 0, 200, 1);
    push_job(0, 1, 2, 1, 210, 1);
    wait_idle(200);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      int c;
      c = int'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0)
        push_job(c, 0, 66, bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 0);
      else
        push_job(c, int'($urandom_range(0, 3)), int'($urandom_range(1, 8)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                 bit'($urandom_range(0, 1)));
    end
    wait_idle(20000);

    // Reset mid-burst with a read pending, then clients 1 and 2 together.
    push_job(2, 0, 10, 0, 30, 1);
    wait_sig("ack", 2, 1, 50);
    @(negedge clk);
    do_reset();
    push_job(1, 0, 2, 0, 40, 1);
    push_job(2, 0, 2, 1, 44, 1);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
